// File: rtl/irq_pkg.sv
// Shared types and sizes for the irq_pend8 interrupt pending/arbitration stage.
package irq_pkg;

  localparam int NREQ   = 8;
  localparam int CODE_W = 3;

  // Arbiter FSM: IDLE waits for an eligible request, OFFER holds one code
  // on the handshake until the consumer takes it.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage : irq_pkg

// File: rtl/irq_pend8_if.sv
// Offer handshake between irq_pend8 (master) and its consumer (slave).
// code is only meaningful while valid is high and is held stable until
// the cycle in which valid & ready are both sampled high.
interface irq_pend8_if;
  import irq_pkg::*;

  logic [CODE_W-1:0] code;
  logic              valid;
  logic              ready;

  modport master (
    output code,
    output valid,
    input  ready
  );

  modport slave (
    input  code,
    input  valid,
    output ready
  );

endinterface : irq_pend8_if

// File: rtl/irq_pend8_prio_enc8.sv
// Eight-input priority encoder: reports the highest set bit index and
// whether any bit is set. Purely combinational.
module prio_enc8
  import irq_pkg::*;
(
  input  logic [NREQ-1:0]   in,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Highest-index set bit wins; the ascending scan lets later bits override.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    code = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (in[i]) begin
        code = CODE_W'(i);
      end
    end
  end

  assign any = |in;

endmodule : prio_enc8

// File: rtl/irq_pend8.sv
// irq_pend8: captures request edges (or levels) into pending bits, masks
// them, and offers the highest-index masked pending request as a 3-bit code
// over a valid/ready handshake, clearing the serviced bit on acceptance.
module irq_pend8
  import irq_pkg::*;
#(
  parameter bit EDGE = 1'b1  // 1: sticky rising-edge capture, 0: pending follows req
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic             en,
  irq_pend8_if.master      grant,
  output logic             idle,
  output logic [NREQ-1:0]  pending
);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q;
  logic [NREQ-1:0]   req_q;
  logic [NREQ-1:0]   pend_q, pend_d;

  // ---------------------------------------------------------------------------
  // Derived signals
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]   rise;
  logic [NREQ-1:0]   mpend;
  logic [NREQ-1:0]   clr;
  logic [CODE_W-1:0] win_code;
  logic              win_any;
  logic              accept;
  logic              load_code;

  assign rise   = req & ~req_q;
  assign mpend  = pend_q & mask;
  // valid is decoded straight from the state register, so ready never
  // reaches valid or code combinationally.
  assign accept = (state_q == OFFER) && grant.ready;
  assign clr    = accept ? (NREQ'(1) << code_q) : '0;

  prio_enc8 u_prio_enc8 (
    .in   (mpend),
    .code (win_code),
    .any  (win_any)
  );

  // Previous request levels. Reset to all-ones so lines already high when
  // reset releases are not mistaken for fresh edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others regardless of block order.
      req_q <= '1;
    end else begin
      req_q <= req;
    end
  end

  // Next pending: sticky set-on-rise with set winning over the acceptance
  // clear in edge mode; a plain copy of req in level mode.
  always_comb begin
    pend_d = pend_q;
    if (EDGE) begin
      pend_d = (pend_q & ~clr) | rise;
    end else begin
      pend_d = req;
    end
  end

  // Pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start an offer only from IDLE, and leave OFFER only on
  // acceptance. An offer is never withdrawn, whatever en or mask do.
  always_comb begin
    state_d   = state_q;
    load_code = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && win_any) begin
          state_d   = OFFER;
          load_code = 1'b1;
        end
      end
      OFFER: begin
        if (grant.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Offered code, captured once when the offer starts and frozen until the
  // next offer begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
    end else if (load_code) begin
      code_q <= win_code;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant.valid = (state_q == OFFER);
  assign grant.code  = code_q;
  assign pending     = pend_q;
  assign idle        = (state_q == IDLE) && !(|mpend);

  // ---------------------------------------------------------------------------
  // Handshake properties
  // ---------------------------------------------------------------------------
  // A stalled offer keeps valid high and code unchanged into the next cycle.
  a_offer_held: assert property (
    @(posedge clk) disable iff (!rst_n)
    grant.valid && !grant.ready |=> grant.valid && $stable(grant.code)
  );

  // idle and valid are mutually exclusive.
  a_idle_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(idle && grant.valid)
  );

endmodule : irq_pend8
